// File: rtl/force_accumulator_pkg.sv
// Shared definitions for the n-body force accumulator: 27-bit float layout,
// FSM state encoding and small widths used across the datapath.
package force_accumulator_pkg;

  localparam int FP_W   = 27;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 18;
  localparam int CNT_W  = 8;
  localparam int N_AXIS = 3;

  localparam logic [FP_W-1:0] FP_ZERO = 27'h0;
  localparam logic [FP_W-1:0] FP_ONE  = 27'h1FC0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M1   = 3'd1,
    ST_M2   = 3'd2,
    ST_M3   = 3'd3,
    ST_ACC  = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/fp_add.sv
// 27-bit float adder. The sum is formed combinationally and delayed through
// LAT-1 registers, so a consumer register captures it LAT edges after the
// operands are applied. Reset is active-low.
module fp_add
  import force_accumulator_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] y
);

  fp_t                     a_f;
  fp_t                     b_f;
  fp_t                     big;
  fp_t                     sml;
  logic [EXP_W-1:0]        diff;
  logic [MAN_W+3:0]        big_m;
  logic [MAN_W+3:0]        sml_m;
  logic [MAN_W+3:0]        sml_al;
  logic [MAN_W+4:0]        sum;
  logic [MAN_W+4:0]        norm;
  logic [4:0]              msb;
  logic signed [EXP_W+1:0] exp_r;
  logic [FP_W-1:0]         res;

  assign a_f = a;
  assign b_f = b;

  always_comb begin
    if ({a_f.exp, a_f.man} >= {b_f.exp, b_f.man}) begin
      big = a_f;
      sml = b_f;
    end else begin
      big = b_f;
      sml = a_f;
    end
    diff   = big.exp - sml.exp;
    big_m  = (big.exp == '0) ? '0 : {1'b1, big.man, 3'b000};
    sml_m  = (sml.exp == '0) ? '0 : {1'b1, sml.man, 3'b000};
    sml_al = (diff > 8'd21) ? '0 : (sml_m >> diff);
    if (big.sign == sml.sign) begin
      sum = {1'b0, big_m} + {1'b0, sml_al};
    end else begin
      sum = {1'b0, big_m} - {1'b0, sml_al};
    end
    msb = 5'd0;
    for (int i = 0; i < MAN_W + 5; i++) begin
      if (sum[i]) msb = 5'(i);
    end
    // hidden bit of the larger operand sits at bit 21; renormalise around it
    norm  = sum << (5'd22 - msb);
    exp_r = $signed({2'b00, big.exp}) + $signed({5'b0, msb}) - 10'sd21;
    res   = FP_ZERO;
    if (sum != '0) begin
      if (exp_r >= 10'sd255) begin
        res = {big.sign, 8'hFF, {MAN_W{1'b0}}};
      end else if (exp_r > 10'sd0) begin
        res = {big.sign, exp_r[EXP_W-1:0], norm[MAN_W+3 -: MAN_W]};
      end
    end
  end

  generate
    if (LAT <= 1) begin : g_comb
      logic unused_pipe;
      assign unused_pipe = clk ^ rst_n;
      assign y = res;
    end else begin : g_pipe
      logic [FP_W-1:0] stage_q [LAT-1];
      logic [FP_W-1:0] stage_d [LAT-1];

      always_comb begin
        stage_d[0] = res;
        for (int i = 1; i < LAT - 1; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT - 1; i++) begin
            stage_q[i] <= FP_ZERO;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign y = stage_q[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/fp_mul.sv
// Combinational 27-bit float multiplier. Zero exponent is treated as zero,
// mantissa is truncated, overflow saturates to the largest exponent.
module fp_mul
  import force_accumulator_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] y
);

  fp_t                      a_f;
  fp_t                      b_f;
  logic                     sign;
  logic                     hi;
  logic [2*MAN_W+1:0]       prod;
  logic signed [EXP_W+2:0]  exp_s;

  assign a_f  = a;
  assign b_f  = b;
  assign sign = a_f.sign ^ b_f.sign;
  assign prod = (2*MAN_W+2)'({1'b1, a_f.man}) * (2*MAN_W+2)'({1'b1, b_f.man});
  assign hi   = prod[2*MAN_W+1];

  always_comb begin
    exp_s = $signed({3'b000, a_f.exp}) + $signed({3'b000, b_f.exp})
          - 11'sd127 + $signed({10'b0, hi});
    y = FP_ZERO;
    if (a_f.exp != '0 && b_f.exp != '0) begin
      if (exp_s >= 11'sd255) begin
        y = {sign, 8'hFF, {MAN_W{1'b0}}};
      end else if (exp_s > 11'sd0) begin
        // product of two [1,2) mantissas lies in [1,4); hi picks the window
        y = {sign, exp_s[EXP_W-1:0],
             hi ? prod[2*MAN_W -: MAN_W] : prod[2*MAN_W-1 -: MAN_W]};
      end
    end
  end

endmodule

// File: rtl/force_accumulator.sv
// Accumulates m_j*(1/r)^3*(dx,dy,dz) over all pairs of one target body and
// emits the acceleration vector after the pair flagged last.
module force_accumulator
  import force_accumulator_pkg::*;
#(
  parameter int ADD_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_last,
  input  logic [FP_W-1:0] i_inv_r,
  input  logic [FP_W-1:0] i_mass,
  input  logic [FP_W-1:0] i_dx,
  input  logic [FP_W-1:0] i_dy,
  input  logic [FP_W-1:0] i_dz,
  output logic            o_valid,
  output logic [FP_W-1:0] o_ax,
  output logic [FP_W-1:0] o_ay,
  output logic [FP_W-1:0] o_az
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic [FP_W-1:0]   inv_r_q, inv_r_d;
  logic [FP_W-1:0]   mass_q, mass_d;
  logic [FP_W-1:0]   r2_q, r2_d;
  logic [FP_W-1:0]   k1_q, k1_d;
  logic [FP_W-1:0]   k_q, k_d;
  logic [FP_W-1:0]   disp_q [N_AXIS];
  logic [FP_W-1:0]   disp_d [N_AXIS];
  logic [FP_W-1:0]   p_q    [N_AXIS];
  logic [FP_W-1:0]   p_d    [N_AXIS];
  logic [FP_W-1:0]   acc_q  [N_AXIS];
  logic [FP_W-1:0]   acc_d  [N_AXIS];
  logic [FP_W-1:0]   res_q  [N_AXIS];
  logic [FP_W-1:0]   res_d  [N_AXIS];

  logic [FP_W-1:0]   r2_w;
  logic [FP_W-1:0]   k1_w;
  logic [FP_W-1:0]   k_w;
  logic [FP_W-1:0]   p_w    [N_AXIS];
  logic [FP_W-1:0]   sum_w  [N_AXIS];
  logic              add_rst_n;

  assign add_rst_n = ~i_rst;

  // one multiplier level per state keeps every path a single fp_mul deep
  fp_mul u_mul_r2 (.a(inv_r_q), .b(inv_r_q), .y(r2_w));
  fp_mul u_mul_k1 (.a(mass_q),  .b(inv_r_q), .y(k1_w));
  fp_mul u_mul_k  (.a(r2_q),    .b(k1_q),    .y(k_w));

  for (genvar gi = 0; gi < N_AXIS; gi++) begin : g_axis
    fp_mul u_mul_p (
      .a (k_q),
      .b (disp_q[gi]),
      .y (p_w[gi])
    );
    fp_add #(.LAT(ADD_LAT)) u_add (
      .clk   (i_clk),
      .rst_n (add_rst_n),
      .a     (acc_q[gi]),
      .b     (p_q[gi]),
      .y     (sum_w[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    valid_d = 1'b0;
    inv_r_d = inv_r_q;
    mass_d  = mass_q;
    r2_d    = r2_q;
    k1_d    = k1_q;
    k_d     = k_q;
    disp_d  = disp_q;
    p_d     = p_q;
    acc_d   = acc_q;
    res_d   = res_q;
    o_ready = (state_q == ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          inv_r_d   = i_inv_r;
          mass_d    = i_mass;
          disp_d[0] = i_dx;
          disp_d[1] = i_dy;
          disp_d[2] = i_dz;
          last_d    = i_last;
          state_d   = ST_M1;
        end
      end
      ST_M1: begin
        r2_d    = r2_w;
        k1_d    = k1_w;
        state_d = ST_M2;
      end
      ST_M2: begin
        k_d     = k_w;
        state_d = ST_M3;
      end
      ST_M3: begin
        p_d     = p_w;
        cnt_d   = CNT_W'(ADD_LAT - 1);
        state_d = ST_ACC;
      end
      ST_ACC: begin
        if (cnt_q == '0) begin
          acc_d = sum_w;
          // outputs take the final sum on the same edge so they are valid in OUT
          if (last_q) begin
            res_d   = sum_w;
            valid_d = 1'b1;
            state_d = ST_OUT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OUT: begin
        for (int i = 0; i < N_AXIS; i++) begin
          acc_d[i] = FP_ZERO;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      inv_r_q <= FP_ZERO;
      mass_q  <= FP_ZERO;
      r2_q    <= FP_ZERO;
      k1_q    <= FP_ZERO;
      k_q     <= FP_ZERO;
      for (int i = 0; i < N_AXIS; i++) begin
        disp_q[i] <= FP_ZERO;
        p_q[i]    <= FP_ZERO;
        acc_q[i]  <= FP_ZERO;
        res_q[i]  <= FP_ZERO;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      inv_r_q <= inv_r_d;
      mass_q  <= mass_d;
      r2_q    <= r2_d;
      k1_q    <= k1_d;
      k_q     <= k_d;
      disp_q  <= disp_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign o_valid = valid_q;
  assign o_ax    = res_q[0];
  assign o_ay    = res_q[1];
  assign o_az    = res_q[2];

endmodule

// File: tb/tb_force_accumulator.sv
// Scoreboard bench for force_accumulator: a real-valued model pushes the
// expected vector per group, a negedge monitor pops and compares on o_valid.
module tb_force_accumulator;
  import force_accumulator_pkg::*;

  localparam int ADD_LAT = 1;
  localparam int PERIOD  = ADD_LAT + 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            i_last = 1'b0;
  logic [FP_W-1:0] i_inv_r = '0;
  logic [FP_W-1:0] i_mass = '0;
  logic [FP_W-1:0] i_dx = '0;
  logic [FP_W-1:0] i_dy = '0;
  logic [FP_W-1:0] i_dz = '0;
  logic            o_ready;
  logic            o_valid;
  logic [FP_W-1:0] o_ax;
  logic [FP_W-1:0] o_ay;
  logic [FP_W-1:0] o_az;

  typedef struct {
    logic [FP_W-1:0] ax;
    logic [FP_W-1:0] ay;
    logic [FP_W-1:0] az;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   xfer_edge = 0;
  int   valid_edge = 0;
  real  sum_x = 0.0;
  real  sum_y = 0.0;
  real  sum_z = 0.0;

  force_accumulator #(.ADD_LAT(ADD_LAT)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_last  (i_last),
    .i_inv_r (i_inv_r),
    .i_mass  (i_mass),
    .i_dx    (i_dx),
    .i_dy    (i_dy),
    .i_dz    (i_dz),
    .o_valid (o_valid),
    .o_ax    (o_ax),
    .o_ay    (o_ay),
    .o_az    (o_az)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FP_W-1:0] to_fp(input real v);
    logic            s;
    int              e;
    real             a;
    logic [MAN_W-1:0] f;
    if (v == 0.0) return FP_ZERO;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    f = MAN_W'($rtoi((a - 1.0) * 262144.0));
    return {s, 8'(e), f};
  endfunction

  function automatic logic [FP_W-1:0] canon(input logic [FP_W-1:0] x);
    return (x == 27'h4000000) ? FP_ZERO : x;
  endfunction

  task automatic model_add(input real ir, input real m, input real dx, input real dy,
                           input real dz, input bit last);
    real  k;
    exp_t e;
    k = m * ir * ir * ir;
    sum_x += k * dx;
    sum_y += k * dy;
    sum_z += k * dz;
    if (last) begin
      e.ax = to_fp(sum_x);
      e.ay = to_fp(sum_y);
      e.az = to_fp(sum_z);
      exp_q.push_back(e);
      sum_x = 0.0;
      sum_y = 0.0;
      sum_z = 0.0;
    end
  endtask

  task automatic send_pair(input real ir, input real m, input real dx, input real dy,
                           input real dz, input bit last);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!o_ready) begin
      check_val("ready_timeout", 32'(o_ready), 32'd1);
      return;
    end
    i_valid   = 1'b1;
    i_inv_r   = to_fp(ir);
    i_mass    = to_fp(m);
    i_dx      = to_fp(dx);
    i_dy      = to_fp(dy);
    i_dz      = to_fp(dz);
    i_last    = last;
    xfer_edge = cyc + 1;
    $display("in  inv_r=%h m=%h dx=%h dy=%h dz=%h last=%0d", i_inv_r, i_mass, i_dx, i_dy, i_dz, last);
    model_add(ir, m, dx, dy, dz, last);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      valid_edge = cyc;
      $display("out ax=%h ay=%h az=%h", o_ax, o_ay, o_az);
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 32'(o_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("ax", 32'(canon(o_ax)), 32'(mon_e.ax));
        check_val("ay", 32'(canon(o_ay)), 32'(mon_e.ay));
        check_val("az", 32'(canon(o_az)), 32'(mon_e.az));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_cons;
    int  total_cons;
    int  last_cons;
    int  gap_exp;
    real dxv, dyv, dzv;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_ready", 32'(o_ready), 32'd1);
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_ax", 32'(o_ax), 32'd0);
    check_val("rst_ay", 32'(o_ay), 32'd0);
    check_val("rst_az", 32'(o_az), 32'd0);

    // unit pair and its latency, counted inclusively from the transfer cycle
    send_pair(1.0, 1.0, 2.0, 0.0, 0.0, 1'b1);
    wait_drain();
    check_val("latency", 32'(valid_edge - xfer_edge + 2), 32'(PERIOD + 1));

    send_pair(0.5, 1.0, 2.0, 0.0, 0.0, 1'b1);
    wait_drain();
    send_pair(0.5, 4.0, 1.0, -2.0, 3.0, 1'b1);
    wait_drain();

    send_pair(1.0, 1.0, 1.0, 0.5, 0.0, 1'b0);
    send_pair(1.0, 1.0, 1.0, 0.25, -1.0, 1'b1);
    wait_drain();
    send_pair(1.0, 1.0, 1.0, 0.0, 0.0, 1'b1);
    wait_drain();

    send_pair(1.0, 1.0, 1.0, 0.0, 0.0, 1'b0);
    send_pair(1.0, 1.0, -1.0, 0.0, 0.0, 1'b1);
    wait_drain();

    // i_valid held high with fresh data every cycle; groups of four pairs
    n_cons     = 0;
    total_cons = 0;
    last_cons  = -1;
    gap_exp    = PERIOD;
    @(negedge clk);
    for (int i = 0; i < 42; i++) begin
      dxv     = real'(i % 5 + 1);
      dyv     = -real'(i % 3);
      dzv     = 0.5 * real'(i % 4);
      i_valid = 1'b1;
      i_inv_r = to_fp(1.0);
      i_mass  = to_fp(1.0);
      i_dx    = to_fp(dxv);
      i_dy    = to_fp(dyv);
      i_dz    = to_fp(dzv);
      i_last  = (n_cons == 3);
      if (o_ready) begin
        if (last_cons >= 0) check_val("ready_gap", 32'(cyc - last_cons), 32'(gap_exp));
        $display("in  bp dx=%h dy=%h dz=%h last=%0d", i_dx, i_dy, i_dz, i_last);
        gap_exp   = i_last ? PERIOD + 1 : PERIOD;
        last_cons = cyc;
        model_add(1.0, 1.0, dxv, dyv, dzv, i_last);
        n_cons = i_last ? 0 : n_cons + 1;
        total_cons++;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    check_val("bp_consumed", 32'(total_cons), 32'd8);
    wait_drain();

    // reset lands in M2 of the second pair; the group must vanish silently
    send_pair(1.0, 1.0, 1.0, 1.0, 1.0, 1'b0);
    send_pair(1.0, 1.0, 1.0, 1.0, 1.0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    sum_x = 0.0;
    sum_y = 0.0;
    sum_z = 0.0;
    @(negedge clk);
    check_val("mid_rst_ready", 32'(o_ready), 32'd1);
    check_val("mid_rst_valid", 32'(o_valid), 32'd0);
    check_val("mid_rst_ax", 32'(o_ax), 32'd0);
    check_val("mid_rst_ay", 32'(o_ay), 32'd0);
    check_val("mid_rst_az", 32'(o_az), 32'd0);
    repeat (10) @(negedge clk);
    send_pair(1.0, 1.0, 2.0, 0.0, 0.0, 1'b1);
    wait_drain();

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/force_accumulator.md
# force_accumulator

Downstream consumer of the fast inverse-square-root stage in the n-body force pipeline. For each interacting body j it takes 1/r, mass m_j and displacement (dx, dy, dz), then forms k = m_j·(1/r)³ and the products k·dx, k·dy, k·dz. It sums those products over all j for one target body i and emits the acceleration vector once the last pair has been accumulated. All arithmetic uses the codebase's 27-bit float: sign[26], exponent[25:18] (bias 127), mantissa[17:0].

## Interface
- ADD_LAT, default 1: latency of the floating-point adder instance in clock cycles; must be ≥1 and match the adder used.
- i_clk  in  1  clock. One clock domain. Reset is synchronous and active-high.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input pair valid.
- o_ready  out  1  block can accept a pair. A transfer occurs only when i_valid and o_ready are both 1 on a rising edge.
- i_last  in  1  marks the final pair for the current target body.
- i_inv_r  in  27  1/r, taken directly from the inverse-sqrt output.
- i_mass  in  27  m_j with G already folded in.
- i_dx, i_dy, i_dz  in  27 each  displacement x_j − x_i (and the y, z equivalents), already formed upstream.
- o_valid  out  1  one-cycle pulse; acceleration outputs are valid in that cycle.
- o_ax, o_ay, o_az  out  27 each  accumulated acceleration; they hold their value until the next o_valid.

## Operation
- FSM states: IDLE → M1 → M2 → M3 → ACC → (OUT if last, else IDLE); OUT → IDLE.
- IDLE: o_ready=1. On transfer, capture all inputs and the last flag into input registers, then go to M1. Whenever the state is not IDLE, o_ready=0 and i_valid is ignored.
- M1: register r2 = inv_r·inv_r and k1 = m·inv_r.
- M2: register k = r2·k1.
- M3: register px = k·dx, py = k·dy, pz = k·dz.
- ACC: three adders compute acc + p in parallel. Hold the state for ADD_LAT cycles using a down-counter. Write the adder results into acc_x, acc_y, acc_z on the final cycle of ACC.
- OUT: drive o_valid=1 and load o_ax/o_ay/o_az from acc. Clear acc to 27'h0 on the same edge, then return to IDLE.
- Multiplications use combinational fp_mul, one level per state. No chained multiplier paths.
- Zero is 27'h0. Sign-magnitude −0 (27'h4000000) is accepted as zero by the bench.
- Single-pair group (i_last=1 on the first pair): the result is simply p added to 0.
- Reset at any point: state←IDLE, counter←0, acc←0, o_ax/o_ay/o_az←0, o_valid←0. Any partial sum is discarded and no o_valid is produced for the aborted group.
- The adder's own reset input is tied to the same reset condition, converted to the polarity the adder instance expects.

## Timing
- Reset values: o_ready=1, o_valid=0, o_ax=o_ay=o_az=27'h0.
- A transfer on edge E0 places the FSM in M1 during the cycle after E0.
- The accumulator is updated on edge E0+3+ADD_LAT.
- Non-last pair: o_ready returns to 1 in the cycle after that accumulator update.
- Last pair: o_valid=1 in the cycle after the accumulator update (state OUT). o_ready returns to 1 one cycle later.
- Throughput: one pair per 4+ADD_LAT cycles. A group adds one extra OUT cycle.
- With ADD_LAT=1, a single last pair has latency E0 → o_valid of 6 cycles.
- i_valid held high across the busy window is not consumed twice. Exactly one transfer happens per IDLE cycle in which i_valid=1.

## Structure
- The shared FP header/package holds FP_W=27, EXP_W=8, MAN_W=18, FP_ZERO=27'h0, FP_ONE=27'h1FC0000, and the FSM state encodings.
- No new sub-module. Reuse the existing fp_mul (combinational) ×3 lanes plus the two M1 and one M2 instances.
- Reuse the existing pipelined FpAdd ×3, one per axis.

## Test plan
- Unit pair: inv_r=27'h1FC0000 (1.0), m=1.0, dx=27'h2000000 (2.0), dy=dz=0, last=1 → exactly one o_valid with ax=27'h2000000 and ay=az=0. Measure the E0→o_valid latency at 4+ADD_LAT+1.
- Scaling: inv_r=27'h1F80000 (0.5), m=1.0, dx=2.0, last=1 → ax=27'h1F40000 (0.25).
- Accumulation: two pairs, each inv_r=1.0, m=1.0, dx=1.0, with last on the second → one o_valid, ax=27'h2000000. Then a following single pair with dx=1.0 → ax=27'h1FC0000, which confirms acc was cleared.
- Cancellation: dx=+1.0 then dx=−1.0 (27'h5FC0000), last on the second → ax exponent=0 (±0).
- Backpressure: hold i_valid=1 continuously with changing data. Check that o_ready=1 only in IDLE cycles, that exactly one pair is consumed per IDLE cycle, and that the sum matches only the consumed pairs.
- Reset mid-group: assert i_rst for 1 cycle during M2 of the second pair → outputs return to their reset values with no o_valid. A fresh group with dx=2.0 then yields ax=2.0.
